// File: rtl/dmem_pkg.sv
// dmem_pkg: shared encodings and helpers for the byte-enabled data memory.
// Holds the RISC-V funct3 size codes, the byte-enable type and the
// alignment / byte-enable helper functions.
package dmem_pkg;

    localparam int WORD_BYTES = 4;

    // RISC-V load/store funct3 size codes; any other code is illegal.
    typedef enum logic [2:0] {
        SZ_B  = 3'b000,
        SZ_H  = 3'b001,
        SZ_W  = 3'b010,
        SZ_BU = 3'b100,
        SZ_HU = 3'b101
    } size_e;

    // One enable bit per byte lane of a word.
    typedef logic [WORD_BYTES-1:0] be_t;

    // True when the size code is legal and the byte offset suits it.
    function automatic logic size_aligned(input logic [2:0] size, input logic [1:0] off);
        logic ok;
        case (size)
            SZ_B, SZ_BU: ok = 1'b1;
            SZ_H, SZ_HU: ok = ~off[0];
            SZ_W:        ok = (off == 2'b00);
            default:     ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Byte lanes touched by an access of this size at this offset.
    // Only the lane count matters here, so signedness (size[2]) is ignored.
    function automatic be_t size_be(input logic [2:0] size, input logic [1:0] off);
        be_t be;
        case (size[1:0])
            2'b00:   be = be_t'(4'b0001 << off);
            2'b01:   be = be_t'(4'b0011 << off);
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational lane steering for data_mem_be.
// Store side: alignment check, byte enables and data shifted into lanes.
// Load side: selects the addressed lanes of a word and sign/zero extends.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wd,
    output logic        aligned,
    output be_t         be,
    output logic [31:0] wd_lane,
    input  logic [31:0] ld_word,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_off,
    output logic [31:0] ld_data
);

    logic [31:0] shifted;

    // Store-side: legality, lane enables and right-aligned data moved to its lanes.
    always_comb begin
        aligned = size_aligned(size, off);
        be      = size_be(size, off);
        wd_lane = wd << {off, 3'b000};
    end

    // Load-side: bring the addressed lanes down to bit 0, then extend.
    always_comb begin
        shifted = ld_word >> {ld_off, 3'b000};
        case (ld_size)
            SZ_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
            SZ_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
            SZ_W:    ld_data = shifted;
            SZ_BU:   ld_data = {24'h0, shifted[7:0]};
            SZ_HU:   ld_data = {16'h0, shifted[15:0]};
            default: ld_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/data_mem_be.sv
// data_mem_be: single-port 32-bit data memory with byte-lane stores and
// sign/zero-extending loads, one cycle of load latency.
// Optional macro DMEM_BYPASS_EN: a load and an aligned store in the same
// cycle return the merged new word; otherwise the old word (read-first).
//
// Request/response: mem_read / mem_write are one-cycle requests sampled on
// the rising edge of clk_50 (no back-pressure, always accepted). The result
// of each request is presented for exactly one cycle after that edge:
// rd_valid=1 with rd for a load, misalign_err=1 for a misaligned or illegal
// access. rd keeps its last value when no load result is presented.
module data_mem_be
    import dmem_pkg::*;
#(
    parameter int    DEPTH     = 1024,
    parameter string INIT_FILE = ""
) (
    input  logic        clk_50,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] wd,
    input  logic [2:0]  size,
    output logic [31:0] rd,
    output logic        rd_valid,
    output logic        misalign_err
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] idx;
    logic          acc_aligned;
    be_t           st_be;
    logic [31:0]   wd_lane;
    logic [31:0]   be_mask;
    logic          store_en;
    logic [31:0]   rd_word_next;
    logic [31:0]   ld_data;

    // Load pipeline: word and extraction controls captured with the request.
    logic          ld_valid_q;
    logic          ld_bad_q;
    logic          err_q;
    logic [31:0]   ld_word_q;
    logic [2:0]    ld_size_q;
    logic [1:0]    ld_off_q;

    // Address bits above the array wrap away.
    logic          unused_addr;
    assign unused_addr = ^addr[31:AW+2];

    dmem_lane_align u_align (
        .size    (size),
        .off     (addr[1:0]),
        .wd      (wd),
        .aligned (acc_aligned),
        .be      (st_be),
        .wd_lane (wd_lane),
        .ld_word (ld_word_q),
        .ld_size (ld_size_q),
        .ld_off  (ld_off_q),
        .ld_data (ld_data)
    );

    // Decode the word index, the lane mask and whether a store may commit.
    always_comb begin
        idx      = addr[AW+1:2];
        be_mask  = {{8{st_be[3]}}, {8{st_be[2]}}, {8{st_be[1]}}, {8{st_be[0]}}};
        store_en = mem_write && acc_aligned;
    end

    // Word handed to the load pipeline: old contents, or merged with a same-cycle store.
    always_comb begin
        rd_word_next = mem[idx];
`ifdef DMEM_BYPASS_EN
        if (store_en) begin
            rd_word_next = (mem[idx] & ~be_mask) | (wd_lane & be_mask);
        end
`endif
    end

    // Byte-lane store; reset only blocks writes, it never clears contents.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            // contents are retained through reset
        end else if (store_en) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (st_be[i]) begin
                    mem[idx][8*i +: 8] <= wd_lane[8*i +: 8];
                end
            end
        end
    end

    // Capture load requests and the one-cycle error pulse.
    always_ff @(posedge clk_50 or negedge rst_n) begin
        if (!rst_n) begin
            ld_valid_q <= 1'b0;
            ld_bad_q   <= 1'b0;
            err_q      <= 1'b0;
            ld_word_q  <= 32'h0;
            ld_size_q  <= SZ_W;
            ld_off_q   <= 2'b00;
        end else begin
            ld_valid_q <= mem_read;
            err_q      <= (mem_read || mem_write) && !acc_aligned;
            if (mem_read) begin
                ld_word_q <= rd_word_next;
                ld_size_q <= size;
                ld_off_q  <= addr[1:0];
                ld_bad_q  <= !acc_aligned;
            end
        end
    end

    // Bad loads read as zero; the registers hold rd steady between loads.
    always_comb begin
        rd           = ld_bad_q ? 32'h0 : ld_data;
        rd_valid     = ld_valid_q;
        misalign_err = err_q;
    end

endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed vector table, reset sequence and randomized
// traffic for data_mem_be (DEPTH=16 so address wrap is exercised).
// Reference model is a flat byte array with little-endian gather/scatter.
module tb_data_mem_be;

    localparam int DEPTH = 16;
    localparam int NBYTES = DEPTH * 4;

    logic        clk_50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wd = 32'h0;
    logic [2:0]  size = 3'b010;
    logic [31:0] rd;
    logic        rd_valid;
    logic        misalign_err;

    int n_cmp = 0;
    int n_fail = 0;

    logic [7:0]  mbytes [NBYTES];
    logic [31:0] last_rd = 32'h0;
    logic [33:0] exp_q [$];

    typedef struct {
        logic        r;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  s;
        logic [31:0] e_rd;
        logic        e_v;
        logic        e_err;
        string       name;
    } vec_t;

    vec_t vecs [$];

    data_mem_be #(.DEPTH(DEPTH)) dut (
        .clk_50       (clk_50),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .addr         (addr),
        .wd           (wd),
        .size         (size),
        .rd           (rd),
        .rd_valid     (rd_valid),
        .misalign_err (misalign_err)
    );

    // ---------------- clock ----------------
    always #10 clk_50 = ~clk_50;

    // ---------------- checking ----------------
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_outs(input string nm, input logic [31:0] e_rd, input logic e_v, input logic e_err);
        check({nm, ".rd"}, rd, e_rd);
        check({nm, ".rd_valid"}, {31'h0, rd_valid}, {31'h0, e_v});
        check({nm, ".misalign_err"}, {31'h0, misalign_err}, {31'h0, e_err});
    endtask

    // ---------------- reference model ----------------
    function automatic int access_bytes(input logic [2:0] s);
        if (s == 3'b010) return 4;
        if (s == 3'b001 || s == 3'b101) return 2;
        return 1;
    endfunction

    function automatic logic access_ok(input logic [2:0] s, input logic [31:0] a);
        logic legal;
        legal = (s == 3'b000) || (s == 3'b001) || (s == 3'b010) || (s == 3'b100) || (s == 3'b101);
        return legal && ((a % access_bytes(s)) == 0);
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] s, input logic [31:0] a);
        int n;
        logic [31:0] v;
        n = access_bytes(s);
        v = 32'h0;
        for (int i = 0; i < n; i++) begin
            v = v | (32'(mbytes[int'((a + 32'(i)) % NBYTES)]) << (8 * i));
        end
        if ((s == 3'b000 || s == 3'b001) && v[8*n-1]) begin
            v = v | (32'hFFFF_FFFF << (8 * n));
        end
        return v;
    endfunction

    task automatic model_store(input logic [2:0] s, input logic [31:0] a, input logic [31:0] d);
        int n;
        n = access_bytes(s);
        for (int i = 0; i < n; i++) begin
            mbytes[int'((a + 32'(i)) % NBYTES)] = d[8*i +: 8];
        end
    endtask

    task automatic model_step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                              input logic [2:0] s, output logic [31:0] e_rd, output logic e_v,
                              output logic e_err);
        logic ok;
        logic [31:0] ld;
        ok = access_ok(s, a);
`ifdef DMEM_BYPASS_EN
        if (w && ok) model_store(s, a, d);
        ld = model_load(s, a);
`else
        ld = model_load(s, a);
        if (w && ok) model_store(s, a, d);
`endif
        e_rd    = r ? (ok ? ld : 32'h0) : last_rd;
        last_rd = e_rd;
        e_v     = r;
        e_err   = (r || w) && !ok;
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; returns at the falling edge after the sampling edge.
    task automatic apply(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] s);
        mem_read  = r;
        mem_write = w;
        addr      = a;
        wd        = d;
        size      = s;
        @(posedge clk_50);
        @(negedge clk_50);
    endtask

    function automatic vec_t mk(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                                input logic [2:0] s, input logic [31:0] e_rd, input logic e_v,
                                input logic e_err, input string name);
        vec_t v;
        v.r = r; v.w = w; v.a = a; v.d = d; v.s = s;
        v.e_rd = e_rd; v.e_v = e_v; v.e_err = e_err; v.name = name;
        return v;
    endfunction

    function automatic logic [2:0] rand_size();
        int k;
        k = $urandom_range(0, 9);
        case (k)
            0, 1:    return 3'b000;
            2, 3:    return 3'b001;
            4, 5:    return 3'b010;
            6:       return 3'b100;
            7:       return 3'b101;
            8:       return 3'b011;
            default: return 3'($urandom_range(6, 7));
        endcase
    endfunction

    // ---------------- test ----------------
    initial begin : main
        logic [31:0] e_rd;
        logic        e_v;
        logic        e_err;
        logic [31:0] bypass_val;
        logic [33:0] exp_word;

`ifdef DMEM_BYPASS_EN
        bypass_val = 32'h2222_2222;
`else
        bypass_val = 32'h1111_1111;
`endif

        // Reset held with a load requested: outputs stay cleared.
        mem_read = 1'b1;
        repeat (3) @(negedge clk_50);
        check_outs("reset_hold", 32'h0, 1'b0, 1'b0);
        mem_read = 1'b0;
        rst_n = 1'b1;
        @(negedge clk_50);
        check_outs("post_reset_idle", 32'h0, 1'b0, 1'b0);

        // Prime every word to zero so the model knows the contents.
        for (int i = 0; i < DEPTH; i++) begin
            model_step(1'b0, 1'b1, 32'(i * 4), 32'h0, 3'b010, e_rd, e_v, e_err);
            apply(1'b0, 1'b1, 32'(i * 4), 32'h0, 3'b010);
        end
        check_outs("prime_done", 32'h0, 1'b0, 1'b0);

        // Directed vectors: {r, w, addr, wd, size, rd, rd_valid, misalign_err}
        vecs.push_back(mk(0, 1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        0, 0, "sw_deadbeef"));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1, 0, "lw_deadbeef"));
        vecs.push_back(mk(0, 1, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 0, 0, "sw_clear10"));
        vecs.push_back(mk(0, 1, 32'h13,  32'h80,       3'b000, 32'hDEADBEEF, 0, 0, "sb_80"));
        vecs.push_back(mk(1, 0, 32'h13,  32'h0,        3'b000, 32'hFFFFFF80, 1, 0, "lb_13"));
        vecs.push_back(mk(1, 0, 32'h13,  32'h0,        3'b100, 32'h00000080, 1, 0, "lbu_13"));
        vecs.push_back(mk(1, 0, 32'h10,  32'h0,        3'b010, 32'h80000000, 1, 0, "lw_after_sb"));
        vecs.push_back(mk(0, 1, 32'h22,  32'h1234,     3'b001, 32'h80000000, 0, 0, "sh_1234"));
        vecs.push_back(mk(1, 0, 32'h21,  32'h0,        3'b001, 32'h0,        1, 1, "lh_misaligned"));
        vecs.push_back(mk(1, 0, 32'h20,  32'h0,        3'b010, 32'h12340000, 1, 0, "lw_after_sh"));
        vecs.push_back(mk(0, 1, 32'h23,  32'hBEEF,     3'b001, 32'h12340000, 0, 1, "sh_misaligned"));
        vecs.push_back(mk(1, 0, 32'h20,  32'h0,        3'b010, 32'h12340000, 1, 0, "lw_unchanged"));
        vecs.push_back(mk(1, 0, 32'h22,  32'h0,        3'b001, 32'h00001234, 1, 0, "lh_pos"));
        vecs.push_back(mk(1, 0, 32'h12,  32'h0,        3'b001, 32'hFFFF8000, 1, 0, "lh_neg"));
        vecs.push_back(mk(1, 0, 32'h12,  32'h0,        3'b101, 32'h00008000, 1, 0, "lhu"));
        vecs.push_back(mk(0, 1, 32'h40,  32'h11111111, 3'b010, 32'h00008000, 0, 0, "sw_1111"));
        vecs.push_back(mk(1, 1, 32'h40,  32'h22222222, 3'b010, bypass_val,   1, 0, "rw_same_cycle"));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        3'b010, 32'h22222222, 1, 0, "lw_after_rw"));
        vecs.push_back(mk(0, 1, 32'h40,  32'hA5,       3'b010, 32'h22222222, 0, 0, "sw_a5_wrap"));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        3'b010, 32'h000000A5, 1, 0, "lw_wrap"));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        3'b011, 32'h0,        1, 1, "load_size011"));
        vecs.push_back(mk(0, 0, 32'h0,   32'h0,        3'b010, 32'h0,        0, 0, "idle_hold"));
        vecs.push_back(mk(0, 1, 32'h0,   32'hFFFFFFFF, 3'b111, 32'h0,        0, 1, "store_size111"));
        vecs.push_back(mk(1, 0, 32'h0,   32'h0,        3'b010, 32'h000000A5, 1, 0, "lw_after_illegal"));
        vecs.push_back(mk(1, 0, 32'h2,   32'h0,        3'b010, 32'h0,        1, 1, "lw_misaligned"));
        vecs.push_back(mk(1, 0, 32'h100, 32'h0,        3'b000, 32'hFFFFFFA5, 1, 0, "lb_wrap"));

        foreach (vecs[i]) begin
            model_step(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s, e_rd, e_v, e_err);
            apply(vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].s);
            check_outs(vecs[i].name, vecs[i].e_rd, vecs[i].e_v, vecs[i].e_err);
        end

        // Reset in the cycle after a load, with a store that must be dropped.
        model_step(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, e_rd, e_v, e_err);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        check_outs("lw_before_reset", 32'h000000A5, 1'b1, 1'b0);
        mem_read  = 1'b0;
        mem_write = 1'b1;
        addr      = 32'h0;
        wd        = 32'h5;
        size      = 3'b010;
        rst_n     = 1'b0;
        #1;
        check_outs("reset_async", 32'h0, 1'b0, 1'b0);
        @(posedge clk_50);
        @(negedge clk_50);
        check_outs("reset_during_store", 32'h0, 1'b0, 1'b0);
        mem_write = 1'b0;
        rst_n     = 1'b1;
        last_rd   = 32'h0;
        apply(1'b0, 1'b0, 32'h0, 32'h0, 3'b010);
        check_outs("idle_after_reset", 32'h0, 1'b0, 1'b0);
        model_step(1'b1, 1'b0, 32'h0, 32'h0, 3'b010, e_rd, e_v, e_err);
        apply(1'b1, 1'b0, 32'h0, 32'h0, 3'b010);
        check_outs("lw_store_dropped", 32'h000000A5, 1'b1, 1'b0);

        // Randomized traffic against the byte-array model.
        for (int t = 0; t < 400; t++) begin
            logic        r;
            logic        w;
            logic [31:0] a;
            logic [31:0] d;
            logic [2:0]  s;
            int          kind;
            kind = $urandom_range(0, 9);
            r = (kind <= 3) || (kind >= 7);
            w = (kind >= 4) && (kind <= 8);
            s = rand_size();
            a = 32'($urandom_range(0, 255));
            if ($urandom_range(0, 9) < 7) begin
                a = a & ~32'(access_bytes(s) - 1);
            end
            d = $urandom;
            model_step(r, w, a, d, s, e_rd, e_v, e_err);
            exp_q.push_back({e_err, e_v, e_rd});
            apply(r, w, a, d, s);
            exp_word = exp_q.pop_front();
            check_outs($sformatf("rand%0d", t), exp_word[31:0], exp_word[32], exp_word[33]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
